// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: handshake, flush and status bundle for pipe_skid_stage.
interface pipe_skid_stage_if #(parameter int WIDTH = 32) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with synchronous flush.
// Define PIPE_SKID_STAGE_SKID_EN for a second skid entry and a registered-only in_ready.
module pipe_skid_stage #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input logic               clk,
    input logic               rst_n,
    pipe_skid_stage_if.slave  bus
);
`ifdef PIPE_SKID_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    logic [WIDTH-1:0] skid_q, skid_nx;
`else
    typedef enum logic {EMPTY, FULL} state_t;
`endif
    state_t           state, state_nx;
    logic [WIDTH-1:0] main_q, main_nx;
    logic             acc, emit;
    assign bus.out_valid = state != EMPTY;
    assign bus.out_data  = main_q;
    assign acc           = bus.in_valid & bus.in_ready;
    assign emit          = bus.out_valid & bus.out_ready;
`ifdef PIPE_SKID_STAGE_SKID_EN
    assign bus.in_ready  = rst_n & (state != SKID);
    assign bus.occupancy = state == SKID ? 2'd2 : {1'b0, state == FULL};
`else
    // single entry: a draining head frees the slot in the same cycle
    assign bus.in_ready  = rst_n & (!bus.out_valid | bus.out_ready);
    assign bus.occupancy = {1'b0, state == FULL};
`endif
    always_comb begin
        state_nx = state;
        main_nx  = main_q;
`ifdef PIPE_SKID_STAGE_SKID_EN
        skid_nx  = skid_q;
`endif
        case (state)
            EMPTY: begin
                state_nx = acc ? FULL : EMPTY;
                main_nx  = acc ? bus.in_data : main_q;
            end
            FULL: begin
                if (acc && emit) begin
                    main_nx = bus.in_data;
                end else if (emit) begin
                    state_nx = EMPTY;
                    main_nx  = BUBBLE_VALUE;
`ifdef PIPE_SKID_STAGE_SKID_EN
                end else if (acc) begin
                    state_nx = SKID;
                    skid_nx  = bus.in_data;
`endif
                end
            end
`ifdef PIPE_SKID_STAGE_SKID_EN
            SKID: begin
                state_nx = emit ? FULL : SKID;
                main_nx  = emit ? skid_q : main_q;
            end
`endif
            default: begin
                state_nx = EMPTY;
                main_nx  = BUBBLE_VALUE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VALUE;
        end else begin
            state  <= state_nx;
            main_q <= main_nx;
        end
    end
`ifdef PIPE_SKID_STAGE_SKID_EN
    // skid contents are don't-care while empty, so no reset is needed
    always_ff @(posedge clk) skid_q <= skid_nx;
`endif
endmodule
